// File: rtl/cva6_mem_responder.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module      : cva6_mem_responder                                         |
// | Description : Memory-side responder for the LSU. Serves one load at a    |
// |               time after a fixed latency, with forwarding from the store |
// |               queue. Committed stores are buffered and drained to a word |
// |               memory, one store_mem_resp pulse per write.                |
// | Ports       : clk_i, rst_ni (sync, active-low)                           |
// |               load_req_i/load_addr_i -> load_ready_o, load_mem_resp_o,   |
// |               load_data_o                                                |
// |               store_commit_i/store_addr_i/store_data_i -> store_ready_o, |
// |               store_mem_resp_o, sq_count_o                               |
// | Revision    : 1.0 - initial release                                      |
// +--------------------------------------------------------------------------+
module cva6_mem_responder #(
  parameter int LOAD_LATENCY  = 3,
  parameter int STORE_LATENCY = 1,
  parameter int SQ_DEPTH      = 4,
  parameter int MEM_WORDS     = 32
) (
  input  logic                          clk_i,
  input  logic                          rst_ni,
  input  logic                          load_req_i,
  input  logic [31:0]                   load_addr_i,
  output logic                          load_ready_o,
  output logic                          load_mem_resp_o,
  output logic [31:0]                   load_data_o,
  input  logic                          store_commit_i,
  input  logic [31:0]                   store_addr_i,
  input  logic [31:0]                   store_data_i,
  output logic                          store_ready_o,
  output logic                          store_mem_resp_o,
  output logic [$clog2(SQ_DEPTH):0]     sq_count_o
);

  localparam int c_IW = $clog2(MEM_WORDS);
  localparam int c_PW = $clog2(SQ_DEPTH);
  localparam int c_CW = c_PW + 1;

  localparam logic [1:0] c_ST_IDLE = 2'd0;
  localparam logic [1:0] c_ST_WAIT = 2'd1;
  localparam logic [1:0] c_ST_RESP = 2'd2;

  // Backing memory and store-queue storage (not reset)
  logic [31:0]     r_mem     [MEM_WORDS];
  logic [c_IW-1:0] r_sq_idx  [SQ_DEPTH];
  logic [31:0]     r_sq_data [SQ_DEPTH];

  logic [1:0]      r_state, w_state_nxt;
  logic [2:0]      r_cnt;
  logic [c_IW-1:0] r_idx;
  logic [31:0]     r_load_data;

  logic [c_PW-1:0] r_wr_ptr, r_rd_ptr;
  logic [c_CW-1:0] r_count;
  logic [2:0]      r_dwell;
  logic            r_cooldown;
  logic            r_store_resp;

  logic            w_load_accept;
  logic            w_enter_resp;
  logic [c_IW-1:0] w_rd_idx;
  logic            w_fwd_hit;
  logic [31:0]     w_fwd_data;
  logic [c_PW-1:0] w_slot;
  logic [31:0]     w_load_word;
  logic            w_sq_full;
  logic            w_enq;
  logic            w_deq;
  logic            w_unused_addr;

  // Only the word-index bits of each address are used
  assign w_unused_addr = ^{load_addr_i, store_addr_i};

  // ---------------------------------------------------------------- load FSM
  always_ff @(posedge clk_i) begin
    if (!rst_ni) r_state <= c_ST_IDLE;
    else         r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    unique case (r_state)
      c_ST_IDLE: if (load_req_i) w_state_nxt = (LOAD_LATENCY == 1) ? c_ST_RESP : c_ST_WAIT;
      c_ST_WAIT: if (r_cnt == 3'd0) w_state_nxt = c_ST_RESP;
      c_ST_RESP: w_state_nxt = c_ST_IDLE;
      default:   w_state_nxt = c_ST_IDLE;
    endcase
  end

  always_comb begin
    load_ready_o    = (r_state == c_ST_IDLE);
    load_mem_resp_o = (r_state == c_ST_RESP);
    load_data_o     = (r_state == c_ST_RESP) ? r_load_data : 32'd0;
  end

  assign w_load_accept = (r_state == c_ST_IDLE) && load_req_i;
  assign w_enter_resp  = (w_state_nxt == c_ST_RESP) && (r_state != c_ST_RESP);
  // With a latency of 1 the data is sampled on the accepting edge itself
  assign w_rd_idx      = (r_state == c_ST_IDLE) ? load_addr_i[c_IW+1:2] : r_idx;

  // Youngest matching queue entry wins: walk oldest to youngest, last hit sticks
  always_comb begin
    w_fwd_hit  = 1'b0;
    w_fwd_data = 32'd0;
    w_slot     = '0;
    for (int i = 0; i < SQ_DEPTH; i++) begin
      w_slot = r_rd_ptr + c_PW'(i);
      if ((c_CW'(i) < r_count) && (r_sq_idx[w_slot] == w_rd_idx)) begin
        w_fwd_hit  = 1'b1;
        w_fwd_data = r_sq_data[w_slot];
      end
    end
  end

  assign w_load_word = w_fwd_hit ? w_fwd_data : r_mem[w_rd_idx];

  // WAIT counts remaining edges; RESP is entered when it has reached zero
  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      r_cnt       <= 3'd0;
      r_idx       <= '0;
      r_load_data <= 32'd0;
    end else begin
      if (w_load_accept) begin
        r_idx <= load_addr_i[c_IW+1:2];
        r_cnt <= 3'(LOAD_LATENCY - 1);
      end else if ((r_state == c_ST_WAIT) && (r_cnt != 3'd0)) begin
        r_cnt <= r_cnt - 3'd1;
      end
      if (w_enter_resp) r_load_data <= w_load_word;
    end
  end

  // ------------------------------------------------------------- store queue
  assign w_sq_full     = (r_count == c_CW'(SQ_DEPTH));
  assign w_enq         = store_commit_i && !w_sq_full;
  assign w_deq         = (r_count != '0) && !r_cooldown &&
                         (r_dwell == 3'(STORE_LATENCY - 1));
  assign store_ready_o    = !w_sq_full;
  assign store_mem_resp_o = r_store_resp;
  assign sq_count_o       = r_count;

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      r_wr_ptr     <= '0;
      r_rd_ptr     <= '0;
      r_count      <= '0;
      r_dwell      <= 3'd0;
      r_cooldown   <= 1'b0;
      r_store_resp <= 1'b0;
    end else begin
      if (w_enq) r_wr_ptr <= r_wr_ptr + c_PW'(1);
      if (w_deq) r_rd_ptr <= r_rd_ptr + c_PW'(1);
      if (w_enq && !w_deq)      r_count <= r_count + c_CW'(1);
      else if (!w_enq && w_deq) r_count <= r_count - c_CW'(1);
      // Dwell restarts for each new head; the edge after a write is a dead cycle
      if ((r_count != '0) && !r_cooldown) r_dwell <= w_deq ? 3'd0 : r_dwell + 3'd1;
      r_cooldown   <= w_deq;
      r_store_resp <= w_deq;
    end
  end

  // Storage writes are suppressed during reset so dropped stores never land
  always_ff @(posedge clk_i) begin
    if (rst_ni && w_enq) begin
      r_sq_idx[r_wr_ptr]  <= store_addr_i[c_IW+1:2];
      r_sq_data[r_wr_ptr] <= store_data_i;
    end
    if (rst_ni && w_deq) r_mem[r_sq_idx[r_rd_ptr]] <= r_sq_data[r_rd_ptr];
  end

endmodule
`default_nettype wire

// File: tb/tb_cva6_mem_responder.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module      : tb_cva6_mem_responder                                      |
// | Description : Scoreboard bench for cva6_mem_responder. Stimulus pushes   |
// |               expected load data/edges and store-write edges; a monitor |
// |               on the falling edge pops and compares on each pulse.       |
// | Revision    : 1.0 - initial release                                      |
// +--------------------------------------------------------------------------+
module tb_cva6_mem_responder;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        load_req;
  logic [31:0] load_addr;
  logic        load_ready;
  logic        load_resp;
  logic [31:0] load_data;
  logic        store_commit;
  logic [31:0] store_addr;
  logic [31:0] store_data;
  logic        store_ready;
  logic        store_resp;
  logic [2:0]  sq_count;

  always #5 clk = ~clk;

  cva6_mem_responder dut (
    .clk_i           (clk),
    .rst_ni          (rst_n),
    .load_req_i      (load_req),
    .load_addr_i     (load_addr),
    .load_ready_o    (load_ready),
    .load_mem_resp_o (load_resp),
    .load_data_o     (load_data),
    .store_commit_i  (store_commit),
    .store_addr_i    (store_addr),
    .store_data_i    (store_data),
    .store_ready_o   (store_ready),
    .store_mem_resp_o(store_resp),
    .sq_count_o      (sq_count)
  );

  int          cyc = 0;
  int          n_pass = 0;
  int          n_total = 0;
  bit          mon_en = 1'b0;
  logic [31:0] exp_ld_data[$];
  int          exp_ld_edge[$];
  int          exp_st_edge[$];

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%08h, expected 0x%08h (edge %0d)", name, act, exp, cyc);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic st(input logic [31:0] a, input logic [31:0] d);
    store_commit = 1'b1;
    store_addr   = a;
    store_data   = d;
    step();
    store_commit = 1'b0;
  endtask

  // Issue a load and record the expected data at issue edge + 3
  task automatic ld(input logic [31:0] a, input logic [31:0] d);
    load_req  = 1'b1;
    load_addr = a;
    step();
    load_req  = 1'b0;
    exp_ld_data.push_back(d);
    exp_ld_edge.push_back(cyc + 3);
  endtask

  // Monitor: edge counter at the falling edge names the edge that produced the pulse
  always @(negedge clk) begin
    if (mon_en) begin
      if (load_resp) begin
        if (exp_ld_data.size() == 0) chk("unexpected_load_resp", 32'd1, 32'd0);
        else begin
          chk("load_data", load_data, exp_ld_data.pop_front());
          chk("load_edge", cyc, exp_ld_edge.pop_front());
        end
      end else begin
        chk("load_data_idle", load_data, 32'd0);
      end
      if (store_resp) begin
        if (exp_st_edge.size() == 0) chk("unexpected_store_resp", 32'd1, 32'd0);
        else chk("store_edge", cyc, exp_st_edge.pop_front());
      end
    end
  end

  logic [31:0] setup_a [5] = '{32'h54, 32'h04, 32'h60, 32'h64, 32'h10};
  logic [31:0] setup_d [5] = '{32'h12345678, 32'hA5A50001, 32'h600D0001,
                               32'h600D0002, 32'h0BADF00D};
  logic [31:0] bur_a   [8] = '{32'h40, 32'h44, 32'h48, 32'h4C, 32'h50, 32'h10, 32'h10, 32'h54};
  logic [31:0] bur_d   [8] = '{32'h1, 32'h2, 32'h3, 32'h4, 32'h5, 32'h44, 32'h55, 32'h99};
  logic [2:0]  bur_cnt [8] = '{3'd1, 3'd1, 3'd2, 3'd2, 3'd3, 3'd3, 3'd4, 3'd3};
  logic        bur_rdy [8] = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1};

  initial begin
    int e0;
    rst_n        = 1'b0;
    load_req     = 1'b0;
    load_addr    = 32'd0;
    store_commit = 1'b0;
    store_addr   = 32'd0;
    store_data   = 32'd0;
    step();
    mon_en = 1'b1;
    step();
    step();
    rst_n = 1'b1;
    repeat (5) step();
    chk("rst_load_ready", load_ready, 1);
    chk("rst_store_ready", store_ready, 1);
    chk("rst_load_resp", load_resp, 0);
    chk("rst_store_resp", store_resp, 0);
    chk("rst_sq_count", sq_count, 0);

    // Known memory contents for later tests
    for (int i = 0; i < 5; i++) begin
      st(setup_a[i], setup_d[i]);
      exp_st_edge.push_back(cyc + 1);
      step();
      step();
    end

    // Single store then load of the same word after it drained
    st(32'h8, 32'hDEADBEEF);
    e0 = cyc;
    exp_st_edge.push_back(e0 + 1);
    chk("single_sq_count", sq_count, 1);
    step();
    step();
    ld(32'h8, 32'hDEADBEEF);
    repeat (6) step();

    // Burst of commits filling the queue; load of a queued word forwards the youngest
    for (int i = 0; i < 8; i++) begin
      store_commit = 1'b1;
      store_addr   = bur_a[i];
      store_data   = bur_d[i];
      if (i == 7) begin
        load_req  = 1'b1;
        load_addr = 32'h10;
      end
      step();
      if (i == 0) begin
        e0 = cyc;
        for (int k = 0; k < 7; k++) exp_st_edge.push_back(e0 + 1 + 2 * k);
      end
      if (i == 7) begin
        exp_ld_data.push_back(32'h55);
        exp_ld_edge.push_back(cyc + 3);
      end
      chk("burst_sq_count", sq_count, bur_cnt[i]);
      chk("burst_store_ready", store_ready, bur_rdy[i]);
    end
    store_commit = 1'b0;
    load_req     = 1'b0;
    repeat (10) step();
    chk("drained_sq_count", sq_count, 0);
    ld(32'h40, 32'h1);
    repeat (4) step();
    ld(32'h54, 32'h12345678);   // dropped commit never reached memory
    repeat (4) step();
    ld(32'h10, 32'h55);
    repeat (4) step();

    // Address wrap, and requests during WAIT are ignored
    ld(32'h84, 32'hA5A50001);
    chk("wait_load_ready", load_ready, 0);
    load_req  = 1'b1;
    load_addr = 32'h8;
    step();
    step();
    load_req = 1'b0;
    repeat (4) step();

    // Reset with a load in WAIT and two stores queued
    st(32'h68, 32'h1);
    e0 = cyc;
    exp_st_edge.push_back(e0 + 1);
    store_commit = 1'b1;
    store_addr   = 32'h60;
    store_data   = 32'hBAD1;
    load_req     = 1'b1;
    load_addr    = 32'h60;
    step();
    store_commit = 1'b0;
    load_req     = 1'b0;
    st(32'h64, 32'hBAD2);
    chk("pre_reset_sq_count", sq_count, 2);
    rst_n = 1'b0;
    step();
    rst_n = 1'b1;
    chk("post_reset_sq_count", sq_count, 0);
    chk("post_reset_load_ready", load_ready, 1);
    chk("post_reset_store_ready", store_ready, 1);
    repeat (8) step();
    ld(32'h60, 32'h600D0001);
    repeat (4) step();
    ld(32'h64, 32'h600D0002);
    repeat (9) step();

    chk("pending_load_resps", exp_ld_data.size(), 0);
    chk("pending_store_resps", exp_st_edge.size(), 0);
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
`default_nettype wire
